// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
// Imported by the subtractor top and available to other datapath blocks.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Bit-counter width for an arbitrary operand width, never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The master issues start with A/B; the slave reports busy, done, D and Bout.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  modport master (
    output start, A, B,
    input  busy, done, D, Bout
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, Bout
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
// Purely combinational; reusable wherever a single borrow cell is needed.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, LSB first, one bit per clock through a single full-subtractor cell.
// Operands are captured on the accepting edge; D/Bout change only on the completion edge.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             shift_en;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  logic             d_bit;
  logic             borrow_nxt;

  full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The edge leaving DONE also serves as the earliest accept edge, so a held
  // start yields one operation every WIDTH+1 cycles.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last_bit  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.A;
      b_sr   <= bus.B;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      r_sr   <= {d_bit, r_sr[WIDTH-1:1]};
      borrow <= borrow_nxt;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        d_q    <= {d_bit, r_sr[WIDTH-1:1]};
        bout_q <= borrow_nxt;
      end
    end
  end

  assign bus.busy = (state == S_SHIFT);
  assign bus.done = (state == S_DONE);
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, handshake corners,
// back-to-back starts and asynchronous reset abort, with a result scoreboard.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bout;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_seen;
  exp_t sb_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      done_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: D=%0h Bout=%0b with empty scoreboard", bus.D, bus.Bout);
      end else begin
        e = sb_q.pop_front();
        chk("D", 32'(bus.D), 32'(e.d));
        chk("Bout", 32'(bus.Bout), 32'(e.bout));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] ed, input logic eb);
    exp_t e;
    e.d    = ed;
    e.bout = eb;
    sb_q.push_back(e);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb);
    int base;
    int k;
    base = done_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    push_exp(ed, eb);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    k = 0;
    while (done_seen == base && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("done_count_op", 32'(done_seen - base), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[8];
    int   busy_cnt;
    int   ndone;
    int   done_at;
    int   first_at;
    int   last_at;
    int   base;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vt[0] = '{8'd5,   8'd3,   8'h02, 1'b0};
    vt[1] = '{8'd3,   8'd5,   8'hFE, 1'b1};
    vt[2] = '{8'h00,  8'h01,  8'hFF, 1'b1};
    vt[3] = '{8'hA5,  8'hA5,  8'h00, 1'b0};
    vt[4] = '{8'hFF,  8'h00,  8'hFF, 1'b0};
    vt[5] = '{8'h00,  8'hFF,  8'h01, 1'b1};
    vt[6] = '{8'h80,  8'h7F,  8'h01, 1'b0};
    vt[7] = '{8'h7F,  8'h80,  8'hFF, 1'b1};

    checks    = 0;
    errors    = 0;
    done_seen = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_D", 32'(bus.D), 32'd0);
    chk("rst_Bout", 32'(bus.Bout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency and handshake timing for 5 - 3.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'd5;
    bus.B     = 8'd3;
    push_exp(8'h02, 1'b0);
    busy_cnt = 0;
    ndone    = 0;
    done_at  = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    end
    chk("lat_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("lat_done_pos", 32'(done_at), 32'd9);
    chk("lat_done_pulses", 32'(ndone), 32'd1);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].d, vt[i].bout);
    end

    // Random operands against an arithmetic model.
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 8'(ra - rb), (ra < rb));
    end

    // Extra starts at edges 3 and 8 with different operands must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'd50;
    bus.B     = 8'd20;
    push_exp(8'd30, 1'b0);
    ndone   = 0;
    done_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = (k == 3 || k == 8);
      if (bus.start) begin
        bus.A = 8'($urandom_range(0, 255));
        bus.B = 8'($urandom_range(0, 255));
      end
      if (bus.done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    end
    chk("ign_done_pulses", 32'(ndone), 32'd1);
    chk("ign_done_pos", 32'(done_at), 32'd9);

    // start held for 40 cycles: accepts at edges 0, 9, 18, 27, 36.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'd100;
    bus.B     = 8'd1;
    for (int i = 0; i < 5; i++) push_exp(8'd99, 1'b0);
    ndone    = 0;
    first_at = -1;
    last_at  = -1;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      if (k == 40) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first_at < 0) first_at = k;
        last_at = k;
      end
    end
    chk("b2b_done_pulses", 32'(ndone), 32'd5);
    chk("b2b_first_done", 32'(first_at), 32'd9);
    chk("b2b_period_span", 32'(last_at - first_at), 32'd36);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'd9;
    bus.B     = 8'd4;
    base      = done_seen;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_D", 32'(bus.D), 32'd99);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_D", 32'(bus.D), 32'd0);
    chk("arst_Bout", 32'(bus.Bout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) @(negedge clk);
    chk("arst_no_done", 32'(done_seen - base), 32'd0);
    chk("arst_idle_busy", 32'(bus.busy), 32'd0);
    run_op(8'd7, 8'd2, 8'd5, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
